// File: rtl/uart_rx_core_if.sv
// Host-facing bundle of the UART receive engine: serial line, per-frame
// configuration and the received-byte handshake.
interface uart_rx_core_if #(
  parameter int DATA_W = 8
);
  logic              rx;
  logic [15:0]       baud_div;
  logic [1:0]        parity_cfg;
  logic [DATA_W-1:0] host_rx_data;
  logic              host_rx_dv;
  logic              rx_err;
  logic              rx_busy;

  // Receiver side: consumes the line and configuration, produces the byte.
  modport slave (
    input  rx,
    input  baud_div,
    input  parity_cfg,
    output host_rx_data,
    output host_rx_dv,
    output rx_err,
    output rx_busy
  );

  // Line/host side: drives the line and configuration, consumes the byte.
  modport master (
    output rx,
    output baud_div,
    output parity_cfg,
    input  host_rx_data,
    input  host_rx_dv,
    input  rx_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART serial receive engine. Synchronises rx, validates the start bit at
// mid-bit, shifts DATA_W bits LSB-first, checks optional parity and the stop
// bit, then delivers the byte with a one-cycle dv pulse and an error flag.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_core_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRK_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]         baud_cnt_q, baud_cnt_d;
  logic [15:0]         bd_q, bd_d;
  logic [1:0]          par_q, par_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                err_q, err_d;

  logic                rx_s;
  logic [15:0]         bd_clamp;
  logic                sample;
  logic                par_en;
  logic                par_odd;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  // Divisors below 2 would leave no room for a mid-bit sample.
  assign bd_clamp = (bus.baud_div < 16'd2) ? 16'd2 : bus.baud_div;
  assign sample   = (baud_cnt_q == 16'd0);
  assign par_en   = par_q[0] ^ par_q[1];
  assign par_odd  = (par_q == 2'b10);

  // Synchroniser shift: oldest sample ends up in the top stage (rx_s).
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.rx};
  end

  // All state, counters and registered outputs; reset returns to idle-high line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      baud_cnt_q <= '0;
      bd_q       <= '0;
      par_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      baud_cnt_q <= baud_cnt_d;
      bd_q       <= bd_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath. The baud counter free-runs down to zero and is
  // reloaded with bd-1 at every sample point, so samples land bd cycles apart.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = sample ? baud_cnt_q : baud_cnt_q - 16'd1;
    bd_d       = bd_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // Configuration is frozen here for the whole frame.
          state_d    = START;
          bd_d       = bd_clamp;
          par_d      = bus.parity_cfg;
          baud_cnt_d = (bd_clamp >> 1) - 16'd1;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;  // glitch, not a real start bit
          end else begin
            state_d    = DATA;
            baud_cnt_d = bd_q - 16'd1;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d    = {rx_s, shift_q[DATA_W-1:1]};
          baud_cnt_d = bd_q - 16'd1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          perr_d     = ((^shift_q) ^ rx_s) != par_odd;
          baud_cnt_d = bd_q - 16'd1;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          ferr_d  = ~rx_s;
          state_d = DONE;
        end
      end
      DONE: begin
        data_d  = shift_q;
        dv_d    = 1'b1;
        err_d   = perr_q | ferr_q;
        // A low stop bit may be a break; wait for the line to recover.
        state_d = ferr_q ? BRK_WAIT : IDLE;
      end
      BRK_WAIT: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.host_rx_data = data_q;
  assign bus.host_rx_dv   = dv_q;
  assign bus.rx_err       = err_q;
  assign bus.rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: drives serial frames, watches the host
// outputs with a small monitor and checks data, error flag and timing.
module tb_uart_rx_core;

  logic clk;
  logic rst_n;
  int   cyc;

  uart_rx_core_if #(.DATA_W(8)) bus ();

  uart_rx_core #(.SYNC_STAGES(2), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int errors;

  // Monitor state, sampled 1 time unit after each rising edge.
  int          dv_count;
  int          last_dv_cyc;
  logic        last_err;
  logic [7:0]  last_data;
  int          lone_err;
  int          busy_rise_cyc;
  int          busy_fall_cyc;
  logic        busy_prev;

  initial begin
    cyc = 0; dv_count = 0; last_dv_cyc = -1; last_err = 1'b0; last_data = 8'h00;
    lone_err = 0; busy_rise_cyc = -1; busy_fall_cyc = -1; busy_prev = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (bus.host_rx_dv === 1'b1) begin
      dv_count++;
      last_dv_cyc = cyc;
      last_err    = bus.rx_err;
      last_data   = bus.host_rx_data;
    end
    if (bus.rx_err === 1'b1 && bus.host_rx_dv !== 1'b1) lone_err++;
    if (bus.rx_busy === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
    if (bus.rx_busy !== 1'b1 && busy_prev) busy_fall_cyc = cyc;
    busy_prev = (bus.rx_busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; each bit is held for bd cycles. e0 is the cycle the
  // start bit was applied. The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input logic sbit, input int bd, output int e0);
    e0 = cyc;
    bus.rx = 1'b0;
    repeat (bd) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bd) tick();
    end
    if (has_par) begin
      bus.rx = pbit;
      repeat (bd) tick();
    end
    bus.rx = sbit;
    repeat (bd) tick();
  endtask

  int e0;
  int dv_base;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.baud_div = 16'd16;
    bus.parity_cfg = 2'b00;
    repeat (3) tick();

    // Reset state
    check("rst_data", 32'(bus.host_rx_data), 32'h00);
    check("rst_dv",   32'(bus.host_rx_dv),   32'h0);
    check("rst_err",  32'(bus.rx_err),       32'h0);
    check("rst_busy", 32'(bus.rx_busy),      32'h0);
    rst_n = 1'b1;
    repeat (10) tick();

    // 1: bd=16, no parity, 0xA5. t0 = e0+3 (two sync stages + IDLE edge).
    dv_base = dv_count;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t1_dv_cnt",   32'(dv_count - dv_base), 32'd1);
    check("t1_data",     32'(last_data),          32'hA5);
    check("t1_err",      32'(last_err),           32'h0);
    check("t1_dv_cyc",   32'(last_dv_cyc),        32'(e0 + 3 + 153));
    check("t1_busy_up",  32'(busy_rise_cyc),      32'(e0 + 3));
    check("t1_busy_dn",  32'(busy_fall_cyc),      32'(e0 + 3 + 153));

    // 2: even parity, 0x03, correct parity bit 0 then wrong parity bit 1
    bus.parity_cfg = 2'b01;
    dv_base = dv_count;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t2a_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t2a_data",   32'(last_data),          32'h03);
    check("t2a_err",    32'(last_err),           32'h0);
    check("t2a_dv_cyc", 32'(last_dv_cyc),        32'(e0 + 3 + 8 + 160 + 1));
    dv_base = dv_count;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t2b_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t2b_data",   32'(last_data),          32'h03);
    check("t2b_err",    32'(last_err),           32'h1);

    // 3: odd parity, 0x00 parity 1, stop=0, line held low 40 cycles from stop
    bus.parity_cfg = 2'b10;
    dv_base = dv_count;
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 16, e0);
    repeat (24) tick();
    check("t3_dv_cnt",   32'(dv_count - dv_base), 32'd1);
    check("t3_data",     32'(last_data),          32'h00);
    check("t3_err",      32'(last_err),           32'h1);
    check("t3_brk_busy", 32'(bus.rx_busy),        32'h1);
    bus.rx = 1'b1;
    repeat (10) tick();
    check("t3_brk_exit", 32'(bus.rx_busy),        32'h0);
    check("t3_no_2nd",   32'(dv_count - dv_base), 32'd1);
    dv_base = dv_count;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t3b_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t3b_data",   32'(last_data),          32'h5A);
    check("t3b_err",    32'(last_err),           32'h0);

    // 4: 5-cycle glitch rejected at t0+8, then a valid 0xFF
    bus.parity_cfg = 2'b00;
    dv_base = dv_count;
    e0 = cyc;
    bus.rx = 1'b0;
    repeat (5) tick();
    bus.rx = 1'b1;
    repeat (30) tick();
    check("t4_glitch_up", 32'(busy_rise_cyc),      32'(e0 + 3));
    check("t4_glitch_dn", 32'(busy_fall_cyc),      32'(e0 + 3 + 8));
    check("t4_glitch_dv", 32'(dv_count - dv_base), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t4_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t4_data",   32'(last_data),          32'hFF);
    check("t4_err",    32'(last_err),           32'h0);

    // 5a: baud_div=0 acts as 2
    bus.baud_div = 16'd0;
    dv_base = dv_count;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 2, e0);
    bus.rx = 1'b1;
    repeat (20) tick();
    check("t5_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t5_data",   32'(last_data),          32'h81);
    check("t5_err",    32'(last_err),           32'h0);
    check("t5_dv_cyc", 32'(last_dv_cyc),        32'(e0 + 3 + 1 + 18 + 1));

    // 5b: divisor changed 16 -> 8 mid-frame, frame still timed at 16
    bus.baud_div = 16'd16;
    repeat (5) tick();
    dv_base = dv_count;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, e0);
      begin
        repeat (40) tick();
        bus.baud_div = 16'd8;
      end
    join
    bus.rx = 1'b1;
    repeat (40) tick();
    bus.baud_div = 16'd16;
    check("t5b_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t5b_data",   32'(last_data),          32'hC3);
    check("t5b_err",    32'(last_err),           32'h0);
    check("t5b_dv_cyc", 32'(last_dv_cyc),        32'(e0 + 3 + 153));

    // 6: one-cycle reset in the middle of bit 0 (line high at that moment)
    dv_base = dv_count;
    bus.rx = 1'b0;
    repeat (16) tick();
    bus.rx = 1'b1;
    repeat (6) tick();
    check("t6_busy_pre", 32'(bus.rx_busy), 32'h1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_data", 32'(bus.host_rx_data), 32'h00);
    check("t6_rst_dv",   32'(bus.host_rx_dv),   32'h0);
    check("t6_rst_err",  32'(bus.rx_err),       32'h0);
    check("t6_rst_busy", 32'(bus.rx_busy),      32'h0);
    rst_n = 1'b1;
    repeat (200) tick();
    check("t6_no_dv", 32'(dv_count - dv_base), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, e0);
    bus.rx = 1'b1;
    repeat (40) tick();
    check("t6_dv_cnt", 32'(dv_count - dv_base), 32'd1);
    check("t6_data",   32'(last_data),          32'h3C);
    check("t6_err",    32'(last_err),           32'h0);

    // rx_err never pulses outside a dv cycle
    check("lone_err", 32'(lone_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive engine for the UART block. It is the counterpart of the TX path driven from host_tx_data/host_tx_en. It synchronises the rx line and detects and validates the start bit. It then samples 8 data bits LSB-first, plus an optional parity bit and a stop bit, at mid-bit. Each completed byte is delivered on host_rx_dv/host_rx_data, and rx_err flags parity or framing faults.

Parameters:
SYNC_STAGES, 2, flops in the rx input synchroniser (minimum 2).
DATA_W, 8, data bits per frame.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx  input  1  serial line, asynchronous, idle high
baud_div  input  16  clk cycles per bit; values 0 and 1 are treated as 2
parity_cfg  input  2  00 none, 01 even, 10 odd, 11 none
host_rx_data  output  DATA_W  last received byte, held until the next frame completes
host_rx_dv  output  1  one-cycle pulse, new byte valid
rx_err  output  1  one-cycle pulse coincident with host_rx_dv, parity or framing error
rx_busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst_n low at posedge clk):
  - State goes to IDLE.
  - host_rx_data=0, host_rx_dv=0, rx_err=0, rx_busy=0.
  - Synchroniser flops are set to 1 and all counters to 0.
  - Reset mid-frame abandons the frame with no dv and no err.
- rx_s is the last synchroniser stage. All decisions use rx_s only.
- Config latch: baud_div (after clamping) and parity_cfg are captured on the IDLE->START transition. Changes mid-frame have no effect on that frame.
- Let half = floor(bd/2), where bd is the latched clamped divisor.
- Let t0 be the first edge in IDLE with rx_s=0.
- States:
  - IDLE: on rx_s=0, go to START; bit counter cleared; baud counter loaded for half.
  - START: at t0+half sample rx_s.
    - If 1: false start, return to IDLE, no outputs.
    - If 0: go to DATA.
  - DATA: bit i (i=0..DATA_W-1) is sampled at t0+half+(i+1)*bd and shifted in LSB-first. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: sampled at t0+half+(DATA_W+1)*bd.
    - perr = (XOR of data bits ^ sampled bit) != 0 for even parity.
    - perr = (XOR of data bits ^ sampled bit) != 1 for odd parity.
  - STOP: sampled at the next bit slot.
    - ferr = (sample==0).
    - On the following edge: host_rx_data <= shift register, host_rx_dv <= 1, rx_err <= perr|ferr.
    - Then go to IDLE if sample==1, else to BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a low stop bit or break from being taken as a new start.
- Errored frames still deliver data; software discards them on rx_err.
- Back-to-back frames: a start edge at any cycle after dv is accepted. No dead cycles are required beyond the stop bit.
- The baud counter is 16-bit and down-counting. It reloads bd at each sample point. No wrap-around is possible because bd ≤ 65535.
- host_rx_dv and rx_err are registered outputs. Both are low in every cycle except the single dv cycle.

Test Plan:
1. bd=16, parity none, send 0xA5 with stop=1 -> host_rx_dv pulses exactly once at t0+153; host_rx_data=0xA5; rx_err=0; rx_busy is high from t0 through t0+152.
2. bd=16, even parity, send 0x03 with parity bit 0 -> data=0x03, rx_err=0. Repeat with parity bit 1 -> data=0x03, rx_err=1 coincident with dv.
3. bd=16, odd parity, send 0x00 with parity 1 and then stop=0, rx held low 40 cycles -> dv with rx_err=1; state stays BRK_WAIT, no second dv; after rx rises, next frame 0x5A is received correctly.
4. Glitch: rx low for 5 cycles at bd=16 -> START rejects at t0+8, no dv, rx_busy falls. A following valid frame 0xFF is received with no error.
5. baud_div=0 -> behaves as bd=2; 0x81 is received with dv at t0+1+18+1. Also change baud_div from 16 to 8 mid-frame -> frame still decoded at 16.
6. Reset asserted mid-DATA for 1 cycle -> all outputs 0, no dv. The next full frame 0x3C is decoded correctly.
